// File: rtl/level_score_ctrl.sv
// Game-progress controller: saturating score, per-level countdown and level
// sequencing (PLAY / LEVEL_END / LOSE / WON) for the HUD and object generators.
module level_score_ctrl #(
    parameter int FRAMES_PER_SEC = 30,
    parameter int LEVEL_TIME     = 60,
    parameter int NUM_LEVELS     = 4,
    parameter int TARGET_BASE    = 100,
    parameter int TARGET_STEP    = 100,
    parameter int HOLD_FRAMES    = 90
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        start_key,
    input  logic        hit_pulse,
    input  logic [7:0]  hit_value,
    output logic [2:0]  state,
    output logic [2:0]  level,
    output logic [15:0] score,
    output logic [15:0] target,
    output logic [6:0]  time_left,
    output logic        sec_tick,
    output logic        level_up
);

    localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [FC_W-1:0] FC_LAST     = FC_W'(FRAMES_PER_SEC - 1);
    localparam logic [HC_W-1:0] HC_LAST     = HC_W'(HOLD_FRAMES - 1);
    localparam logic [2:0]      LAST_LEVEL  = 3'(NUM_LEVELS);
    localparam logic [6:0]      TIME_INIT   = 7'(LEVEL_TIME);
    localparam logic [15:0]     TARGET_INIT = 16'(TARGET_BASE);
    localparam logic [16:0]     TARGET_INC  = 17'(TARGET_STEP);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_LEVEL_END = 3'd2,
        S_LOSE      = 3'd3,
        S_WON       = 3'd4
    } state_t;

    state_t          r_state;
    logic [2:0]      r_level;
    logic [15:0]     r_score;
    logic [15:0]     r_target;
    logic [6:0]      r_time_left;
    logic            r_sec_tick;
    logic            r_level_up;
    logic [FC_W-1:0] r_frame_cnt;
    logic [HC_W-1:0] r_hold_cnt;

    state_t          w_state_nxt;
    logic [2:0]      w_level_nxt;
    logic [15:0]     w_score_nxt;
    logic [15:0]     w_target_nxt;
    logic [6:0]      w_time_left_nxt;
    logic            w_sec_tick_nxt;
    logic            w_level_up_nxt;
    logic [FC_W-1:0] w_frame_cnt_nxt;
    logic [HC_W-1:0] w_hold_cnt_nxt;

    logic [16:0]     w_score_sum;
    logic [15:0]     w_score_play;
    logic [16:0]     w_target_sum;
    logic [15:0]     w_target_inc;

    // Sums are formed one bit wider so the carry selects the saturated value.
    assign w_score_sum  = {1'b0, r_score} + {9'd0, hit_value};
    assign w_score_play = !hit_pulse      ? r_score :
                          w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    assign w_target_sum = {1'b0, r_target} + TARGET_INC;
    assign w_target_inc = w_target_sum[16] ? 16'hFFFF : w_target_sum[15:0];

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt     = r_state;
        w_level_nxt     = r_level;
        w_score_nxt     = r_score;
        w_target_nxt    = r_target;
        w_time_left_nxt = r_time_left;
        w_sec_tick_nxt  = 1'b0;
        w_level_up_nxt  = 1'b0;
        w_frame_cnt_nxt = r_frame_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;

        case (r_state)
            S_PLAY: begin
                w_score_nxt = w_score_play;
                if (startOfFrame) begin
                    if (r_frame_cnt == FC_LAST) begin
                        w_frame_cnt_nxt = '0;
                        w_time_left_nxt = r_time_left - 7'd1;
                        w_sec_tick_nxt  = 1'b1;
                        // Final second: judge the level on the score including this cycle's hit.
                        if (r_time_left == 7'd1) begin
                            w_hold_cnt_nxt = '0;
                            if (w_score_play >= r_target)
                                w_state_nxt = (r_level == LAST_LEVEL) ? S_WON : S_LEVEL_END;
                            else
                                w_state_nxt = S_LOSE;
                        end
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + FC_W'(1);
                    end
                end
            end

            S_LEVEL_END: begin
                if (startOfFrame) begin
                    if (r_hold_cnt == HC_LAST) begin
                        w_state_nxt     = S_PLAY;
                        w_level_nxt     = r_level + 3'd1;
                        w_target_nxt    = w_target_inc;
                        w_time_left_nxt = TIME_INIT;
                        w_frame_cnt_nxt = '0;
                        w_hold_cnt_nxt  = '0;
                        w_level_up_nxt  = 1'b1;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + HC_W'(1);
                    end
                end
            end

            S_IDLE, S_LOSE, S_WON: begin
                if (start_key) begin
                    w_state_nxt     = S_PLAY;
                    w_level_nxt     = 3'd1;
                    w_score_nxt     = '0;
                    w_target_nxt    = TARGET_INIT;
                    w_time_left_nxt = TIME_INIT;
                    w_frame_cnt_nxt = '0;
                    w_hold_cnt_nxt  = '0;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_level     <= 3'd1;
            r_score     <= '0;
            r_target    <= TARGET_INIT;
            r_time_left <= TIME_INIT;
            r_sec_tick  <= 1'b0;
            r_level_up  <= 1'b0;
            r_frame_cnt <= '0;
            r_hold_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state     <= w_state_nxt;
            r_level     <= w_level_nxt;
            r_score     <= w_score_nxt;
            r_target    <= w_target_nxt;
            r_time_left <= w_time_left_nxt;
            r_sec_tick  <= w_sec_tick_nxt;
            r_level_up  <= w_level_up_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
        end
    end

    assign state     = r_state;
    assign level     = r_level;
    assign score     = r_score;
    assign target    = r_target;
    assign time_left = r_time_left;
    assign sec_tick  = r_sec_tick;
    assign level_up  = r_level_up;

endmodule

// File: tb/tb_level_score_ctrl.sv
// Scoreboard bench for level_score_ctrl: a frame/level-level reference model queues
// expected output changes, and a monitor pops and compares whenever an output moves.
module tb_level_score_ctrl;

    localparam int FPS  = 30;
    localparam int LT   = 60;
    localparam int NL   = 4;
    localparam int TBAS = 100;
    localparam int TSTP = 100;
    localparam int HOLD = 90;

    localparam int NCH      = 7;
    localparam int C_STATE  = 0;
    localparam int C_LEVEL  = 1;
    localparam int C_SCORE  = 2;
    localparam int C_TARGET = 3;
    localparam int C_TIME   = 4;
    localparam int C_TICK   = 5;
    localparam int C_LVLUP  = 6;

    localparam int ST_IDLE = 0;
    localparam int ST_PLAY = 1;
    localparam int ST_LEND = 2;
    localparam int ST_LOSE = 3;
    localparam int ST_WON  = 4;

    localparam int M_QUIET = 0;
    localparam int M_FAIL  = 1;
    localparam int M_PASS  = 2;
    localparam int M_EXACT = 3;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        start_key;
    logic        hit_pulse;
    logic [7:0]  hit_value;
    logic [2:0]  state;
    logic [2:0]  level;
    logic [15:0] score;
    logic [15:0] target;
    logic [6:0]  time_left;
    logic        sec_tick;
    logic        level_up;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ticks  = 0;

    // Reference model: current expected outputs plus frames elapsed in the level / hold.
    int m     [NCH];
    int m_nxt [NCH];
    int m_elapsed;
    int m_hold;
    int q_exp [NCH][$];

    int mon_now  [NCH];
    int mon_prev [NCH];

    always #5 clk = ~clk;

    level_score_ctrl #(
        .FRAMES_PER_SEC(FPS),
        .LEVEL_TIME    (LT),
        .NUM_LEVELS    (NL),
        .TARGET_BASE   (TBAS),
        .TARGET_STEP   (TSTP),
        .HOLD_FRAMES   (HOLD)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .start_key   (start_key),
        .hit_pulse   (hit_pulse),
        .hit_value   (hit_value),
        .state       (state),
        .level       (level),
        .score       (score),
        .target      (target),
        .time_left   (time_left),
        .sec_tick    (sec_tick),
        .level_up    (level_up)
    );

    function automatic string ch_name(int ch);
        case (ch)
            C_STATE:  return "state";
            C_LEVEL:  return "level";
            C_SCORE:  return "score";
            C_TARGET: return "target";
            C_TIME:   return "time_left";
            C_TICK:   return "sec_tick";
            default:  return "level_up";
        endcase
    endfunction

    function automatic int sat16(int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic int target_of(int lvl);
        return sat16(TBAS + (lvl - 1) * TSTP);
    endfunction

    task automatic check(string name, int actual, int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic void sample_outputs();
        mon_now[C_STATE]  = int'(state);
        mon_now[C_LEVEL]  = int'(level);
        mon_now[C_SCORE]  = int'(score);
        mon_now[C_TARGET] = int'(target);
        mon_now[C_TIME]   = int'(time_left);
        mon_now[C_TICK]   = int'(sec_tick);
        mon_now[C_LVLUP]  = int'(level_up);
    endfunction

    task automatic model_init();
        m[C_STATE]  = ST_IDLE;
        m[C_LEVEL]  = 1;
        m[C_SCORE]  = 0;
        m[C_TARGET] = TBAS;
        m[C_TIME]   = LT;
        m[C_TICK]   = 0;
        m[C_LVLUP]  = 0;
        m_elapsed   = 0;
        m_hold      = 0;
    endtask

    task automatic model_commit();
        for (int ch = 0; ch < NCH; ch++)
            if (m_nxt[ch] != m[ch]) q_exp[ch].push_back(m_nxt[ch]);
        m = m_nxt;
    endtask

    task automatic model_reset();
        m_nxt[C_STATE]  = ST_IDLE;
        m_nxt[C_LEVEL]  = 1;
        m_nxt[C_SCORE]  = 0;
        m_nxt[C_TARGET] = TBAS;
        m_nxt[C_TIME]   = LT;
        m_nxt[C_TICK]   = 0;
        m_nxt[C_LVLUP]  = 0;
        m_elapsed       = 0;
        m_hold          = 0;
        model_commit();
    endtask

    // Level-time view: remaining seconds = LT - elapsed_frames / FPS.
    task automatic model_step(bit sof, bit st, bit hit, int val);
        m_nxt = m;
        m_nxt[C_TICK]  = 0;
        m_nxt[C_LVLUP] = 0;
        case (m[C_STATE])
            ST_PLAY: begin
                if (hit) m_nxt[C_SCORE] = sat16(m[C_SCORE] + (val & 255));
                if (sof) begin
                    m_elapsed++;
                    m_nxt[C_TIME] = LT - m_elapsed / FPS;
                    m_nxt[C_TICK] = (m_elapsed % FPS == 0) ? 1 : 0;
                    if (m_elapsed == LT * FPS) begin
                        m_hold = 0;
                        if (m_nxt[C_SCORE] < m[C_TARGET]) m_nxt[C_STATE] = ST_LOSE;
                        else if (m[C_LEVEL] == NL)        m_nxt[C_STATE] = ST_WON;
                        else                              m_nxt[C_STATE] = ST_LEND;
                    end
                end
            end
            ST_LEND: begin
                if (sof) begin
                    m_hold++;
                    if (m_hold == HOLD) begin
                        m_nxt[C_STATE]  = ST_PLAY;
                        m_nxt[C_LEVEL]  = m[C_LEVEL] + 1;
                        m_nxt[C_TARGET] = target_of(m[C_LEVEL] + 1);
                        m_nxt[C_TIME]   = LT;
                        m_nxt[C_LVLUP]  = 1;
                        m_elapsed       = 0;
                    end
                end
            end
            default: begin
                if (st) begin
                    m_nxt[C_STATE]  = ST_PLAY;
                    m_nxt[C_LEVEL]  = 1;
                    m_nxt[C_SCORE]  = 0;
                    m_nxt[C_TARGET] = target_of(1);
                    m_nxt[C_TIME]   = LT;
                    m_elapsed       = 0;
                end
            end
        endcase
        model_commit();
    endtask

    task automatic cycle(bit sof, bit st, bit hit, int val);
        startOfFrame = sof;
        start_key    = st;
        hit_pulse    = hit;
        hit_value    = 8'(val);
        model_step(sof, st, hit, val);
        @(posedge clk);
        #1;
    endtask

    task automatic play_frame(bit h, int v, bit st);
        cycle(1'b1, 1'b0, h, v);
        cycle(1'b0, st, 1'b0, 0);
    endtask

    task automatic run_level(int mode);
        int total;
        int tgt;
        total = LT * FPS;
        tgt   = m[C_TARGET];
        while (m_elapsed < total - 2) begin
            bit h;
            bit st;
            int v;
            h  = ($urandom_range(0, 7) == 0);
            v  = int'($urandom_range(0, 255));
            st = ($urandom_range(0, 31) == 0);
            if (mode == M_QUIET) h = 1'b0;
            if ((mode == M_FAIL || mode == M_EXACT) && m[C_SCORE] + v >= tgt) h = 1'b0;
            if (mode == M_PASS && m[C_SCORE] < tgt && total - m_elapsed < 40) begin
                h = 1'b1;
                v = 255;
            end
            play_frame(h, v, st);
        end
        if (mode == M_EXACT) play_frame(1'b1, tgt - 1 - m[C_SCORE], 1'b0);
        else                 play_frame(1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, mode == M_EXACT, 1);
        cycle(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic hold_level();
        for (int i = 0; i < HOLD; i++) begin
            cycle(1'b1, 1'b0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 255)));
            if (i == HOLD - 1) begin
                check("level_up high on entry", int'(level_up), 1);
                check("state PLAY after hold", int'(state), ST_PLAY);
            end
            cycle(1'b0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, 7);
        end
        check("level_up one cycle only", int'(level_up), 0);
    endtask

    task automatic check_reset_values(string tag);
        check({tag, " state"},     int'(state), ST_IDLE);
        check({tag, " level"},     int'(level), 1);
        check({tag, " score"},     int'(score), 0);
        check({tag, " target"},    int'(target), TBAS);
        check({tag, " time_left"}, int'(time_left), LT);
        check({tag, " sec_tick"},  int'(sec_tick), 0);
        check({tag, " level_up"},  int'(level_up), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached, bench did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : monitor
        @(negedge clk);
        sample_outputs();
        mon_prev = mon_now;
        forever begin
            @(negedge clk);
            sample_outputs();
            if (sec_tick) n_ticks++;
            for (int ch = 0; ch < NCH; ch++) begin
                if (mon_now[ch] != mon_prev[ch]) begin
                    if (q_exp[ch].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected %s change: got %0d, expected it to stay %0d (t=%0t)",
                                 ch_name(ch), mon_now[ch], mon_prev[ch], $time);
                    end else begin
                        check({"scoreboard ", ch_name(ch)}, mon_now[ch], q_exp[ch].pop_front());
                    end
                end
            end
            mon_prev = mon_now;
        end
    end

    initial begin : driver
        int lose_score;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        start_key    = 1'b0;
        hit_pulse    = 1'b0;
        hit_value    = 8'd0;
        model_init();
        repeat (3) @(posedge clk);
        #2 resetN = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("reset");

        // Hits and frames in IDLE change nothing.
        cycle(1'b0, 1'b0, 1'b1, 50);
        cycle(1'b1, 1'b0, 1'b1, 9);
        check("idle hit score", int'(score), 0);
        check("idle state", int'(state), ST_IDLE);

        // Run A: level 1 passed with 120, level 2 lost.
        cycle(1'b0, 1'b1, 1'b0, 0);
        n_ticks = 0;
        check("start state", int'(state), ST_PLAY);
        check("start level", int'(level), 1);
        check("start score", int'(score), 0);
        check("start target", int'(target), 100);
        check("start time", int'(time_left), 60);
        for (int i = 0; i < 30; i++) play_frame(1'b0, 0, 1'b0);
        check("time after 30 frames", int'(time_left), 59);
        check("sec_tick count", n_ticks, 1);
        play_frame(1'b1, 100, 1'b0);
        play_frame(1'b1, 20, 1'b0);
        check("score 120", int'(score), 120);
        run_level(M_QUIET);
        check("L1 end state", int'(state), ST_LEND);
        check("L1 end score", int'(score), 120);
        check("L1 end time", int'(time_left), 0);
        hold_level();
        check("L2 level", int'(level), 2);
        check("L2 target", int'(target), 200);
        check("L2 time", int'(time_left), 60);
        check("L2 score carried", int'(score), 120);
        run_level(M_FAIL);
        check("lose state", int'(state), ST_LOSE);
        lose_score = m[C_SCORE];
        for (int i = 0; i < 20; i++)
            cycle($urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 1) == 1, int'($urandom_range(1, 255)));
        check("lose frozen score", int'(score), lose_score);
        check("lose frozen state", int'(state), ST_LOSE);
        check("lose frozen time", int'(time_left), 0);

        // Restart together with a frame: that frame must not be counted.
        cycle(1'b1, 1'b1, 1'b0, 0);
        check("restart state", int'(state), ST_PLAY);
        check("restart level", int'(level), 1);
        check("restart score", int'(score), 0);
        check("restart target", int'(target), 100);
        for (int i = 0; i < 29; i++) play_frame(1'b0, 0, 1'b0);
        check("29 frames keep time", int'(time_left), 60);
        play_frame(1'b0, 0, 1'b0);
        check("30th frame ticks", int'(time_left), 59);

        // Run B: exact-target pass via simultaneous hit, then through to WON.
        run_level(M_EXACT);
        check("boundary score", int'(score), 100);
        check("boundary state", int'(state), ST_LEND);
        hold_level();
        run_level(M_PASS);
        hold_level();
        run_level(M_PASS);
        hold_level();
        check("L4 level", int'(level), 4);
        check("L4 target", int'(target), 400);
        run_level(M_PASS);
        check("won state", int'(state), ST_WON);
        check("won level", int'(level), 4);

        // Run C: saturation, level 2 entry, then reset mid-level.
        cycle(1'b0, 1'b1, 1'b0, 0);
        check("restart from won score", int'(score), 0);
        play_frame(1'b1, 200, 1'b0);
        for (int i = 0; i < 260; i++) play_frame(1'b1, 255, 1'b0);
        check("score saturated", int'(score), 65535);
        run_level(M_QUIET);
        check("saturated pass state", int'(state), ST_LEND);
        hold_level();
        check("C L2 level", int'(level), 2);
        for (int i = 0; i < 100; i++)
            play_frame($urandom_range(0, 3) == 0, int'($urandom_range(0, 255)), 1'b0);
        startOfFrame = 1'b0;
        start_key    = 1'b0;
        hit_pulse    = 1'b0;
        #2 resetN = 1'b0;
        model_reset();
        #1;
        check_reset_values("async reset");
        #19 resetN = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++)
            cycle($urandom_range(0, 1) == 1, 1'b0, 1'b1, int'($urandom_range(1, 255)));
        check("post-reset idle score", int'(score), 0);
        check("post-reset idle state", int'(state), ST_IDLE);

        @(negedge clk);
        #1;
        for (int ch = 0; ch < NCH; ch++)
            check({"pending expectations ", ch_name(ch)}, q_exp[ch].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
